// File: rtl/pattern_generator.sv
// pattern_generator: test-pattern pixel source for the TMDS encoders.
// Four patterns (colour bars, scrolling checkerboard, bouncing box, grey ramp)
// selected by mode, which is latched only at the frame tick so the picture
// never tears. RGB is registered: one cycle of latency from x/y.
// Optional build macro PATTERN_CROSSHAIR_EN adds a white crosshair overlay
// through the screen centre.
module pattern_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned BOX_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic [1:0] mode,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_BOX     = 2'd2,
    PAT_RAMP    = 2'd3
  } pattern_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  localparam logic [10:0] X_LIM = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - BOX_SIZE);

  logic        vsync_q;
  logic        armed;
  logic        tick;
  logic [7:0]  frame_cnt;
  pattern_t    mode_q;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  dir_t        dir_x;
  dir_t        dir_y;
  logic [10:0] next_x;
  logic [10:0] next_y;
  logic [2:0]  bar_idx;
  logic        in_box;
  logic        blank;
  logic [23:0] pix;

  // One bounce step for one axis; returns {new direction, new position}.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input dir_t dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir == DIR_POS) begin
      if (p + 11'(BOX_STEP) >= lim) axis_next = {DIR_NEG, lim[9:0]};
      else                          axis_next = {DIR_POS, 10'(p + 11'(BOX_STEP))};
    end else begin
      if (p <= 11'(BOX_STEP)) axis_next = {DIR_POS, 10'd0};
      else                    axis_next = {DIR_NEG, 10'(p - 11'(BOX_STEP))};
    end
  endfunction

  // armed stays low after reset until vsync has been seen low, so a vsync
  // held high across reset release cannot fire a spurious tick.
  assign tick   = vsync & ~vsync_q & armed;
  assign next_x = axis_next(box_x, dir_x, X_LIM);
  assign next_y = axis_next(box_y, dir_y, Y_LIM);

  // Frame edge detection and all per-frame state (mode, counter, box).
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      mode_q     <= PAT_BARS;
      box_x      <= '0;
      box_y      <= '0;
      dir_x      <= DIR_POS;
      dir_y      <= DIR_POS;
    end else begin
      vsync_q    <= vsync;
      armed      <= armed | ~vsync;
      frame_tick <= tick;
      if (tick) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_q    <= pattern_t'(mode);
        box_x     <= next_x[9:0];
        dir_x     <= dir_t'(next_x[10]);
        box_y     <= next_y[9:0];
        dir_y     <= dir_t'(next_y[10]);
      end
    end
  end

  // Pixel colour for the current x/y from the current frame state.
  always_comb begin
    pix     = '0;
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ({1'b0, x} >= 11'(i * (H_ACTIVE / 8))) bar_idx = 3'(i);
    end
    in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
             ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + 11'(BOX_SIZE));
    blank  = ({1'b0, x} >= 11'(H_ACTIVE)) || ({1'b0, y} >= 11'(V_ACTIVE));
    case (mode_q)
      PAT_BARS: begin
        case (bar_idx)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      PAT_CHECKER: begin
        // Only bit 5 of the wrapped x + frame_cnt sum matters.
        pix = (1'((x[5:0] + 6'(frame_cnt)) >> 5) ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      end
      PAT_BOX:  pix = in_box ? 24'hFF0000 : 24'h202020;
      default:  pix = {frame_cnt, frame_cnt, frame_cnt};
    endcase
`ifdef PATTERN_CROSSHAIR_EN
    if (x == 10'(H_ACTIVE / 2) || y == 10'(V_ACTIVE / 2)) pix = '1;
`else
    // no crosshair overlay
`endif
    if (blank) pix = '0;
  end

  // Registered RGB output (one cycle latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= pix[23:16];
      green <= pix[15:8];
      blue  <= pix[7:0];
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: self-checking bench for pattern_generator.
// A frame-level reference model (integer box position/velocity, frame count,
// latched mode) predicts RGB and frame_tick for every driven cycle.
module tb_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic       vsync;
  logic [1:0] mode;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int tick_seen = 0;

  // reference model state
  int m_fc, m_mode, m_bx, m_by, m_vx, m_vy;
  bit m_last;
  bit [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  pattern_generator #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(32), .BOX_STEP(2)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .vsync(vsync), .mode(mode),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fc = 0; m_mode = 0; m_bx = 0; m_by = 0; m_vx = 2; m_vy = 2;
    m_last = 1'b1;  // reset counts as "vsync high": an edge needs vsync low first
  endtask

  function automatic bit [23:0] ref_pix(input int px, input int py);
    bit a;
    if (px >= 640 || py >= 480) return 24'h0;
`ifdef PATTERN_CROSSHAIR_EN
    if (px == 320 || py == 240) return 24'hFFFFFF;
`endif
    case (m_mode)
      0: return bars[px / 80];
      1: begin
        a = ((((px + m_fc) % 1024) / 32) % 2) != ((py / 32) % 2);
        return a ? 24'hFFFFFF : 24'h000000;
      end
      2: return (px >= m_bx && px < m_bx + 32 && py >= m_by && py < m_by + 32)
                ? 24'hFF0000 : 24'h202020;
      default: return {m_fc[7:0], m_fc[7:0], m_fc[7:0]};
    endcase
  endfunction

  task automatic bounce(inout int pos, inout int vel, input int lim);
    pos = pos + vel;
    if (pos >= lim) begin pos = lim; vel = -2; end
    else if (pos <= 0) begin pos = 0; vel = 2; end
  endtask

  // Drive one cycle of inputs, advance the model, check outputs after the edge.
  task automatic step(input int px, input int py, input bit vs, input int md, input bit r);
    bit [23:0] exp_rgb;
    bit        exp_tick;
    x = 10'(px); y = 10'(py); vsync = vs; mode = 2'(md); rst = r;
    if (r) begin
      exp_rgb = '0; exp_tick = 1'b0;
      model_reset();
    end else begin
      exp_rgb  = ref_pix(px, py);
      exp_tick = vs && !m_last;
      m_last   = vs;
      if (exp_tick) begin
        m_fc   = (m_fc + 1) % 256;
        m_mode = md;
        bounce(m_bx, m_vx, 608);
        bounce(m_by, m_vy, 448);
      end
    end
    @(posedge clk);
    #1;
    check_val("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb});
    check_val("frame_tick", {31'h0, frame_tick}, {31'h0, exp_tick});
    if (frame_tick) tick_seen++;
  endtask

  task automatic do_frame(input int md, input int px, input int py);
    step(px, py, 1'b1, md, 1'b0);
    step(px, py, 1'b1, md, 1'b0);
    step(px, py, 1'b0, md, 1'b0);
    step(px, py, 1'b0, md, 1'b0);
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; vsync = 1'b0; mode = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(0, 0, 1'b0, 0, 1'b1);
    step(0, 0, 1'b0, 0, 1'b1);

    // colour bars sweep plus blanking and centre-line pixels
    for (int px = 0; px < 640; px++) step(px, 10, 1'b0, 0, 1'b0);
    step(700, 10, 1'b0, 0, 1'b0);
    step(320, 5, 1'b0, 0, 1'b0);
    step(5, 240, 1'b0, 0, 1'b0);
    step(320, 500, 1'b0, 0, 1'b0);

    // three frames in box mode, then probe box corners
    tick_seen = 0;
    for (int f = 0; f < 3; f++) do_frame(2, 6, 6);
    check_val("tick_count", 32'(tick_seen), 32'd3);
    step(6, 6, 1'b0, 2, 1'b0);
    step(5, 6, 1'b0, 2, 1'b0);
    step(37, 37, 1'b0, 2, 1'b0);
    step(38, 38, 1'b0, 2, 1'b0);

    // full bounce travel on both axes, probing the box edges every frame
    for (int f = 0; f < 620; f++) begin
      do_frame(2, 0, 0);
      step(m_bx, m_by, 1'b0, 2, 1'b0);
      step((m_bx + 1023) % 1024, m_by, 1'b0, 2, 1'b0);
      step(m_bx + 31, m_by + 31, 1'b0, 2, 1'b0);
      step(m_bx + 32, m_by + 32, 1'b0, 2, 1'b0);
    end

    // mode change mid-frame has no effect until the next tick
    do_frame(0, 0, 0);
    for (int i = 0; i < 20; i++) step($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 1, 1'b0);
    do_frame(1, 0, 0);
    step(0, 0, 1'b0, 1, 1'b0);
    step(32, 0, 1'b0, 1, 1'b0);
    step(32, 32, 1'b0, 1, 1'b0);

    // grey ramp across a full frame-counter wrap
    for (int f = 0; f < 257; f++) begin
      do_frame(3, 100, 100);
      step(100, 100, 1'b0, 3, 1'b0);
    end

    // reset mid-line while vsync is high: no tick until vsync returns low
    step(100, 100, 1'b1, 3, 1'b0);
    step(100, 100, 1'b1, 3, 1'b1);
    for (int i = 0; i < 5; i++) step(50 + i, 100, 1'b1, 3, 1'b0);
    step(100, 100, 1'b0, 3, 1'b0);
    step(100, 100, 1'b1, 3, 1'b0);
    step(100, 100, 1'b1, 3, 1'b0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1023), $urandom_range(0, 1023),
           1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
           1'($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
